// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared funct codes, FSM states and defaults for the HI/LO sequencer
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration: shift-add multiply or restoring-divide step
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   top;
    logic [WIDTH-1:0] diff;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        top  = acc_in[2*WIDTH-1:WIDTH-1];
        diff = top[WIDTH-1:0] - operand;
        if (is_div) begin
            if (top >= {1'b0, operand}) begin
                acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {top[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end
        end else if (acc_in[0]) begin
            acc_out = {sum, acc_in[WIDTH-1:1]};
        end else begin
            acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle mult/div sequencer owning the HI/LO registers
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state, state_nxt;
    logic [CW-1:0]      counter;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   operand;
    logic               op_div, neg_q, neg_r, dz;

    logic               accept, start, start_div, is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept    = valid & ~busy;
    assign start     = accept & is_muldiv(funct);
    assign start_div = (funct == FN_DIV) || (funct == FN_DIVU);
    assign is_signed = (funct == FN_MULT) || (funct == FN_DIV);
    assign a_mag     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign b_mag     = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_div),
        .acc_in  (acc),
        .operand (operand),
        .acc_out (acc_step)
    );

    // Sign correction applied in FIX; divide-by-zero forces an all-ones quotient.
    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = dz ? {WIDTH{1'b1}} : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = start_div ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (counter == '0) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        stall = valid & busy;
        if (funct == FN_MFHI) begin
            rd_data = hi;
        end else if (funct == FN_MFLO) begin
            rd_data = lo;
        end else begin
            rd_data = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter  <= '0;
            acc      <= '0;
            operand  <= '0;
            op_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && funct == FN_MTHI) hi <= op_a;
                    if (accept && funct == FN_MTLO) lo <= op_a;
                    if (start) begin
                        counter  <= CW'(WIDTH - 1);
                        operand  <= start_div ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (start_div ? a_mag : b_mag)};
                        op_div   <= start_div;
                        neg_q    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_r    <= is_signed & op_a[WIDTH-1];
                        dz       <= start_div & (op_b == '0);
                        div_zero <= start_div & (op_b == '0);
                    end
                end
                ST_MUL,
                ST_DIV: begin
                    acc     <= acc_step;
                    counter <= counter - 1'b1;
                end
                ST_FIX: begin
                    if (op_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [5:0]  funct;
    logic [31:0] op_a, op_b;
    logic        busy, stall, done, div_zero;
    logic [31:0] rd_data, hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid    (valid),
        .funct    (funct),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .stall    (stall),
        .rd_data  (rd_data),
        .hi       (hi),
        .lo       (lo),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference results from plain integer arithmetic.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (f == FN_MULTU) begin
            p = {32'd0, a} * {32'd0, b};
            eh = p[63:32]; el = p[31:0];
        end else if (f == FN_MULT) begin
            p = 64'(sa * sb);
            eh = p[63:32]; el = p[31:0];
        end else if (b == 32'd0) begin
            eh = a; el = 32'hFFFF_FFFF;
        end else if (f == FN_DIVU) begin
            el = a / b; eh = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            el = 32'h8000_0000; eh = 32'd0;
        end else begin
            q = sa / sb; r = sa % sb;
            el = q[31:0]; eh = r[31:0];
        end
    endfunction

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int edges;
        model(f, a, b, eh, el);
        @(negedge clk);
        valid = 1'b1; funct = f; op_a = a; op_b = b;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_latency"}, 64'(edges), 64'd33);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic move_to(input logic [5:0] f, input logic [31:0] a);
        @(negedge clk);
        valid = 1'b1; funct = f; op_a = a; op_b = 32'd0;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        logic [31:0] eh, el, a, b, hold_hi, hold_lo;
        logic [5:0] f;
        logic [5:0] ops [4];
        int edges, dones;
        ops[0] = FN_MULT; ops[1] = FN_MULTU; ops[2] = FN_DIV; ops[3] = FN_DIVU;

        reset = 1'b1; valid = 1'b0; funct = 6'd0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dz", 64'(div_zero), 64'd0);
        reset = 1'b0;

        run_op("multu_7x6", FN_MULTU, 32'd7, 32'd6);
        @(posedge clk); #1;
        check("done_pulse_width", 64'(done), 64'd0);
        run_op("mult_m3x5", FN_MULT, 32'hFFFF_FFFD, 32'd5);
        run_op("div_m7_2", FN_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_7_2", FN_DIVU, 32'd7, 32'd2);
        run_op("divu_100_0", FN_DIVU, 32'd100, 32'd0);
        check("dz_set", 64'(div_zero), 64'd1);
        run_op("multu_1x1", FN_MULTU, 32'd1, 32'd1);
        check("dz_clear", 64'(div_zero), 64'd0);
        run_op("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_neg_by_0", FN_DIV, 32'hFFFF_FF00, 32'd0);
        run_op("mult_min", FN_MULT, 32'h8000_0000, 32'h8000_0000);

        move_to(FN_MTHI, 32'hDEAD_BEEF);
        move_to(FN_MTLO, 32'h1234_5678);
        check("mthi", 64'(hi), 64'hDEAD_BEEF);
        check("mtlo", 64'(lo), 64'h1234_5678);
        check("mt_busy", 64'(busy), 64'd0);
        valid = 1'b1; funct = FN_MFHI; #1;
        check("mfhi_rd", 64'(rd_data), 64'hDEAD_BEEF);
        funct = FN_MFLO; #1;
        check("mflo_rd", 64'(rd_data), 64'h1234_5678);
        funct = 6'b000000; op_a = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("bad_funct_busy", 64'(busy), 64'd0);
        check("bad_funct_hi", 64'(hi), 64'hDEAD_BEEF);
        check("bad_funct_lo", 64'(lo), 64'h1234_5678);
        @(negedge clk);
        valid = 1'b0;

        // mflo issued while a divide is in flight must stall until done.
        model(FN_DIV, 32'd1000, 32'hFFFF_FFF9, eh, el);
        @(negedge clk);
        valid = 1'b1; funct = FN_DIV; op_a = 32'd1000; op_b = 32'hFFFF_FFF9;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        valid = 1'b1; funct = FN_MFLO;
        edges = 0;
        while (!done && edges < 100) begin
            #1;
            check("mflo_stall", 64'(stall), 64'd1);
            @(posedge clk); #1;
            edges++;
        end
        check("mflo_unstall", 64'(stall), 64'd0);
        check("mflo_new_lo", 64'(rd_data), 64'(el));
        @(negedge clk);
        valid = 1'b0;

        // Asynchronous reset part-way through a multiply.
        @(negedge clk);
        valid = 1'b1; funct = FN_MULT; op_a = 32'd12345; op_b = 32'd678;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        for (int i = 0; i < 20; i++) begin
            f = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = a >> $urandom_range(0, 31); b = b >> $urandom_range(0, 31); end
                2: a = -($urandom_range(1, 1000));
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), f, a, b);
            if (f == FN_DIV || f == FN_DIVU)
                check($sformatf("rand%0d_dz", i), 64'(div_zero), 64'(b == 32'd0));
            else
                check($sformatf("rand%0d_dz", i), 64'(div_zero), 64'd0);
        end

        hold_hi = hi; hold_lo = lo;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
